// File: rtl/uart_pkt_pkg.sv
// Shared definitions for the multi-byte UART packet transmitter:
// frame constants, CRC8 helper and the packet FSM state encoding.
package uart_pkt_pkg;

    localparam logic [7:0] PKT_HEADER = 8'h55;
    localparam logic [7:0] CRC8_POLY  = 8'h07;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_LOAD,
        ST_DONE
    } tx_state_e;

    // One byte of CRC8 (poly 0x07, MSB first, non-reflected).
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 serializer: start bit, eight data bits LSB first, stop bit, each BPS_CNT cycles.
// A new byte may be accepted in the last stop-bit cycle, giving gapless characters.
module uart_byte_tx #(
    parameter int BPS_CNT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       byte_start,
    input  logic [7:0] byte_data,
    output logic       byte_ready,
    output logic       bit_end,
    output logic       txd
);

    localparam int CNT_W = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BPS_CNT - 1);

    logic             r_active;
    logic [CNT_W-1:0] r_baudCnt;
    logic [3:0]       r_bitCnt;
    logic [8:0]       r_shift;
    logic             r_txd;
    logic             w_bitEnd;

    assign w_bitEnd   = r_active && (r_baudCnt == CNT_LAST);
    assign byte_ready = !r_active || (w_bitEnd && (r_bitCnt == 4'd9));
    assign bit_end    = w_bitEnd;
    assign txd        = r_txd;

    // The shift register holds the remaining data bits with the stop bit on top.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_active  <= 1'b0;
            r_baudCnt <= '0;
            r_bitCnt  <= 4'd0;
            r_shift   <= '1;
            r_txd     <= 1'b1;
        end else if (byte_start && byte_ready) begin
            r_active  <= 1'b1;
            r_baudCnt <= '0;
            r_bitCnt  <= 4'd0;
            r_shift   <= {1'b1, byte_data};
            r_txd     <= 1'b0;
        end else if (r_active) begin
            if (w_bitEnd) begin
                r_baudCnt <= '0;
                if (r_bitCnt == 4'd9) begin
                    r_active <= 1'b0;
                end else begin
                    r_bitCnt <= r_bitCnt + 4'd1;
                    r_txd    <= r_shift[0];
                    r_shift  <= {1'b1, r_shift[8:1]};
                end
            end else begin
                r_baudCnt <= r_baudCnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_mult_byte_tx.sv
// Packet transmitter: frames header, length, payload and CRC8 as back-to-back 8N1 characters.
// The FSM owns byte selection, the CRC and the length clamp; uart_byte_tx does the bit timing.
module uart_mult_byte_tx
    import uart_pkt_pkg::*;
#(
    parameter int CLK_FREQ  = 50000000,
    parameter int UART_BPS  = 115200,
    parameter int MAX_BYTES = 11
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    input  logic                   tx_start,
    input  logic [3:0]             tx_len,
    input  logic [8*MAX_BYTES-1:0] tx_payload,
    output logic                   uart_txd,
    output logic                   tx_busy,
    output logic                   tx_done,
    output logic [4:0]             byte_idx
);

    localparam int         BPS_CNT = CLK_FREQ / UART_BPS;
    localparam logic [3:0] MAX_LEN = 4'(MAX_BYTES);

    tx_state_e              r_state;
    logic [8*MAX_BYTES-1:0] r_payload;
    logic [3:0]             r_lenEff;
    logic [7:0]             r_crc;
    logic [4:0]             r_byteIdx;
    logic [2:0]             r_bitCnt;
    logic                   r_busy;
    logic                   r_done;

    logic       w_accept;
    logic       w_byteStart;
    logic [7:0] w_byteData;
    logic       w_byteReady;
    logic       w_bitEnd;
    logic       w_moreBytes;
    logic [3:0] w_lenClamp;
    logic [4:0] w_nextIdx;
    logic [4:0] w_crcIdx;
    logic [4:0] w_payOff;
    logic [7:0] w_nextByte;

    assign w_lenClamp  = (tx_len > MAX_LEN) ? MAX_LEN : tx_len;
    assign w_crcIdx    = {1'b0, r_lenEff} + 5'd2;
    assign w_nextIdx   = r_byteIdx + 5'd1;
    assign w_payOff    = w_nextIdx - 5'd2;
    assign w_moreBytes = (r_byteIdx != w_crcIdx);
    assign w_accept    = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && tx_start;
    assign w_byteStart = w_accept || ((r_state == ST_LOAD) && w_byteReady);
    assign w_byteData  = w_accept ? PKT_HEADER : w_nextByte;

    always_comb begin
        w_nextByte = r_payload[8*w_payOff +: 8];
        if (w_nextIdx == 5'd1) begin
            w_nextByte = {4'h0, r_lenEff};
        end else if (w_nextIdx == w_crcIdx) begin
            w_nextByte = r_crc;
        end
    end

    // STOP hands over to LOAD early in the stop bit; LOAD then fires in its last cycle.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state   <= ST_IDLE;
            r_payload <= '0;
            r_lenEff  <= 4'd0;
            r_crc     <= 8'h00;
            r_byteIdx <= 5'd0;
            r_bitCnt  <= 3'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (tx_start) begin
                        r_payload <= tx_payload;
                        r_lenEff  <= w_lenClamp;
                        r_crc     <= 8'h00;
                        r_byteIdx <= 5'd0;
                        r_busy    <= 1'b1;
                        r_state   <= ST_START;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_START: begin
                    if (w_bitEnd) begin
                        r_bitCnt <= 3'd0;
                        r_state  <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_bitEnd) begin
                        if (r_bitCnt == 3'd7) begin
                            r_state <= ST_STOP;
                        end else begin
                            r_bitCnt <= r_bitCnt + 3'd1;
                        end
                    end
                end
                ST_STOP: begin
                    if (w_moreBytes) begin
                        r_state <= ST_LOAD;
                    end else if (w_byteReady) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_LOAD: begin
                    if (w_byteReady) begin
                        r_byteIdx <= w_nextIdx;
                        if (w_nextIdx != w_crcIdx) begin
                            r_crc <= crc8_byte(r_crc, w_nextByte);
                        end
                        r_state <= ST_START;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign tx_busy  = r_busy;
    assign tx_done  = r_done;
    assign byte_idx = r_byteIdx;

    uart_byte_tx #(
        .BPS_CNT(BPS_CNT)
    ) u_byteTx (
        .clk       (sys_clk),
        .rst       (sys_rst),
        .byte_start(w_byteStart),
        .byte_data (w_byteData),
        .byte_ready(w_byteReady),
        .bit_end   (w_bitEnd),
        .txd       (uart_txd)
    );

endmodule

// File: tb/tb_uart_mult_byte_tx.sv
// Directed bench for uart_mult_byte_tx at BPS_CNT=10: frames are decoded cycle by cycle
// against a table of expected bytes, plus busy, back-to-back and mid-frame reset sequences.
module tb_uart_mult_byte_tx;

    logic        sys_clk;
    logic        sys_rst;
    logic        tx_start;
    logic [3:0]  tx_len;
    logic [87:0] tx_payload;
    logic        uart_txd;
    logic        tx_busy;
    logic        tx_done;
    logic [4:0]  byte_idx;

    int nChecks = 0;
    int nErrors = 0;

    typedef struct {
        logic [3:0]   len;
        logic [87:0]  pay;
        int           n;
        logic [111:0] frame;
        int           inject;
    } vec_t;

    vec_t vecs [5];

    uart_mult_byte_tx #(
        .CLK_FREQ (1000),
        .UART_BPS (100),
        .MAX_BYTES(11)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .tx_start  (tx_start),
        .tx_len    (tx_len),
        .tx_payload(tx_payload),
        .uart_txd  (uart_txd),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done),
        .byte_idx  (byte_idx)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Reference CRC shifted one message bit at a time over length byte and payload.
    function automatic logic [7:0] refCrc(input logic [3:0] n, input logic [87:0] pay);
        logic [7:0] c;
        logic [7:0] b;
        logic       fb;
        c = 8'h00;
        for (int k = 0; k <= int'(n); k++) begin
            b = (k == 0) ? {4'h0, n} : pay[8*(k-1) +: 8];
            for (int j = 7; j >= 0; j--) begin
                fb = c[7] ^ b[j];
                c  = {c[6:0], 1'b0};
                if (fb) c = c ^ 8'h07;
            end
        end
        return c;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] len, input logic [87:0] pay);
        tx_len     = len;
        tx_payload = pay;
        tx_start   = 1'b1;
        @(negedge sys_clk);
        tx_start   = 1'b0;
    endtask

    // Entered in the first start-bit cycle; returns in the cycle after the final stop bit.
    task automatic watchFrame(input logic [111:0] frame, input int n, input int injectAt);
        logic [9:0] got;
        logic [7:0] b8;
        logic       expLvl;
        int         c, b, w;
        int         lvlErr, idxErr, busyErr;
        got     = '0;
        lvlErr  = 0;
        idxErr  = 0;
        busyErr = 0;
        for (int k = 0; k < n * 100; k++) begin
            c  = k / 100;
            b  = (k % 100) / 10;
            w  = k % 10;
            b8 = frame[8*c +: 8];
            if (b == 0) expLvl = 1'b0;
            else if (b == 9) expLvl = 1'b1;
            else expLvl = b8[b-1];
            if (uart_txd !== expLvl) lvlErr++;
            if (byte_idx !== 5'(c)) idxErr++;
            if (tx_busy !== 1'b1 || tx_done !== 1'b0) busyErr++;
            if (w == 5) got[b] = uart_txd;
            if (w == 9 && b == 9)
                checkOutput($sformatf("char%0d", c), 128'(got), 128'({1'b1, b8, 1'b0}));
            if (k == injectAt) begin
                tx_start   = 1'b1;
                tx_len     = 4'd2;
                tx_payload = '1;
            end else begin
                tx_start = 1'b0;
            end
            @(negedge sys_clk);
        end
        checkOutput("bitTiming", 128'(lvlErr), 128'(0));
        checkOutput("byteIdxTrack", 128'(idxErr), 128'(0));
        checkOutput("busyDuringFrame", 128'(busyErr), 128'(0));
        checkOutput("doneAtEnd", 128'(tx_done), 128'(1));
        checkOutput("busyAtEnd", 128'(tx_busy), 128'(0));
        checkOutput("txdAtEnd", 128'(uart_txd), 128'(1));
    endtask

    initial begin
        int quietErr;
        sys_rst    = 1'b1;
        tx_start   = 1'b0;
        tx_len     = 4'd0;
        tx_payload = '0;

        vecs[0] = '{len: 4'd1, pay: 88'hAB, n: 4, frame: 112'h4DAB0155, inject: -1};
        vecs[1] = '{len: 4'd0, pay: 88'hEE, n: 3, frame: 112'h55, inject: -1};
        vecs[2] = '{len: 4'd15, pay: 88'h0A090807060504030201_00, n: 14,
                    frame: {refCrc(4'd11, 88'h0A09080706050403020100), 88'h0A09080706050403020100, 8'h0B, 8'h55},
                    inject: -1};
        vecs[3] = '{len: 4'd3, pay: 88'h81C35A, n: 6,
                    frame: {64'h0, refCrc(4'd3, 88'h81C35A), 40'h81C35A0355}, inject: 350};
        vecs[4] = '{len: 4'd11, pay: {11{8'hFF}}, n: 14,
                    frame: {refCrc(4'd11, {11{8'hFF}}), {11{8'hFF}}, 8'h0B, 8'h55}, inject: -1};

        repeat (3) @(negedge sys_clk);
        checkOutput("rstTxd", 128'(uart_txd), 128'(1));
        checkOutput("rstBusy", 128'(tx_busy), 128'(0));
        checkOutput("rstDone", 128'(tx_done), 128'(0));
        checkOutput("rstIdx", 128'(byte_idx), 128'(0));
        sys_rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            repeat (5) @(negedge sys_clk);
            applyStimulus(vecs[i].len, vecs[i].pay);
            checkOutput($sformatf("vec%0d_startLatency", i), 128'({tx_busy, uart_txd}), 128'(2'b10));
            watchFrame(vecs[i].frame, vecs[i].n, vecs[i].inject);
        end

        // Back-to-back: new request raised in the tx_done cycle.
        repeat (5) @(negedge sys_clk);
        applyStimulus(vecs[0].len, vecs[0].pay);
        watchFrame(vecs[0].frame, vecs[0].n, -1);
        applyStimulus(vecs[1].len, vecs[1].pay);
        checkOutput("b2bStartBit", 128'({tx_busy, uart_txd, byte_idx}), 128'({1'b1, 1'b0, 5'd0}));
        watchFrame(vecs[1].frame, vecs[1].n, -1);

        // Reset during data bit 1 of the first payload character.
        repeat (5) @(negedge sys_clk);
        applyStimulus(4'd2, 88'h113C);
        repeat (225) @(negedge sys_clk);
        checkOutput("preRstBusy", 128'(tx_busy), 128'(1));
        sys_rst = 1'b1;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        checkOutput("midRstTxd", 128'(uart_txd), 128'(1));
        checkOutput("midRstBusy", 128'(tx_busy), 128'(0));
        checkOutput("midRstIdx", 128'(byte_idx), 128'(0));
        quietErr = 0;
        for (int k = 0; k < 500; k++) begin
            if (tx_done !== 1'b0 || uart_txd !== 1'b1 || tx_busy !== 1'b0) quietErr++;
            @(negedge sys_clk);
        end
        checkOutput("quietAfterRst", 128'(quietErr), 128'(0));
        applyStimulus(vecs[3].len, vecs[3].pay);
        watchFrame(vecs[3].frame, vecs[3].n, -1);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule

// File: doc/uart_mult_byte_tx.md
# uart_mult_byte_tx

Multi-byte UART packet transmitter, the send-side counterpart of the multi-byte packet receiver in the PWM/DDS board design. It accepts a payload of up to MAX_BYTES bytes and frames it as header, length, payload and CRC8. It serializes the frame as back-to-back 8N1 characters on `uart_txd`. It sits in the 50 MHz domain and is used for status/readback packets toward the host.

## Interface
- `CLK_FREQ`, 50000000: system clock frequency in Hz.
- `UART_BPS`, 115200: baud rate. BPS_CNT = CLK_FREQ/UART_BPS (integer division), 434 at defaults.
- `MAX_BYTES`, 11: maximum payload bytes. Must be 1..15.
- `sys_clk` input 1: system clock.
- `sys_rst` input 1: synchronous reset, active-high.
- `tx_start` input 1: single-cycle request to send a frame.
- `tx_len` input 4: number of payload bytes; sampled with `tx_start`.
- `tx_payload` input 8*MAX_BYTES: payload; byte k is [8k+7:8k]; sampled with `tx_start`.
- `uart_txd` output 1: serial line, idle high.
- `tx_busy` output 1: frame in progress.
- `tx_done` output 1: one-cycle pulse when a frame completes.
- `byte_idx` output 5: index of the frame byte currently on the line (0 = header).

## Operation
- Frame order: 8'h55 header, length byte {4'h0, len_eff}, payload bytes 0..len_eff-1, CRC8.
- len_eff = min(tx_len, MAX_BYTES). tx_len = 0 is legal and gives the frame 55 00 00.
- CRC8 uses poly 0x07, init 0x00, MSB-first and non-reflected, with no final XOR. It covers the length byte and the payload; the header is excluded.
- CRC is updated byte-serially when each byte is loaded for transmission.
- Each character is 8N1: start bit 0, data bits LSB first, stop bit 1.
- FSM states:
  - IDLE: `tx_start` latches the payload and len_eff, clears the CRC, sets byte_idx=0, and goes to START.
  - START → DATA → STOP.
  - STOP → LOAD when more bytes remain. STOP → DONE after the CRC byte.
  - LOAD: selects the next byte by byte_idx, folds it into the CRC when applicable, and goes to START.
  - DONE: pulses `tx_done` and returns to IDLE.
- `tx_start` while `tx_busy` = 1 is ignored. Payload inputs may change freely after acceptance.
- Reset values: `uart_txd`=1, `tx_busy`=0, `tx_done`=0, `byte_idx`=0. The FSM resets to IDLE and the CRC to 0x00.
- Reset mid-frame: all state returns to reset values at the next edge. The line goes high immediately, leaving a truncated character. No `tx_done` is generated.

## Timing
- `tx_start` is sampled at edge N. At N+1, `tx_busy`=1 and `uart_txd`=0 (header start bit).
- Every bit lasts exactly BPS_CNT cycles. The baud counter runs 0..BPS_CNT-1 and wraps at bit boundaries.
- LOAD absorbs no line time. The next start bit begins in the cycle right after the previous stop bit ends, so the inter-character gap is 0.
- A frame occupies (len_eff+3)*10*BPS_CNT cycles from N+1.
- In the cycle after the final stop bit: `tx_done`=1, `tx_busy`=0, `uart_txd`=1.
- `tx_start` asserted in the `tx_done` cycle is accepted, so a new start bit follows one cycle later.
- `byte_idx` changes exactly at each start-bit boundary.

## Structure
- Package `uart_pkt_pkg` holds:
  - the header constant 8'h55;
  - the CRC poly 8'h07 and the `crc8_byte(crc, data)` function;
  - the FSM state encoding.
- Sub-module `uart_byte_tx` is the 8N1 serializer. Its ports: `byte_start`, `byte_data`, `byte_ready` and `txd`.
- The packet FSM in the top block drives `uart_byte_tx` and owns the CRC, the byte indexing and the length clamp.

## Test plan
All scenarios use CLK_FREQ=1000 and UART_BPS=100 (BPS_CNT=10).
- Basic frame: `tx_len`=1, payload[7:0]=8'hAB, one start pulse.
  - Line decodes 55 01 AB 4D.
  - `tx_done` arrives exactly 400 cycles after the first start-bit cycle.
  - `tx_busy` is high throughout.
- Zero length: `tx_len`=0.
  - Line decodes 55 00 00.
  - `tx_done` arrives after 300 cycles.
- Clamp: `tx_len`=15 with MAX_BYTES=11 and payload bytes 0x00..0x0A.
  - Length byte is 0x0B, followed by 11 payload bytes and a CRC that matches the reference model.
  - Frame is 14 characters long.
- Busy and back-to-back:
  - A second `tx_start` mid-frame is ignored.
  - `tx_start` in the `tx_done` cycle begins a new start bit one cycle later, with no idle bit.
- Reset mid-frame: assert `sys_rst` during a payload data bit.
  - Next edge gives `uart_txd`=1, `tx_busy`=0, `byte_idx`=0.
  - No `tx_done` occurs.
  - A subsequent frame is transmitted correctly.
- Bit timing: check that every bit width equals 10 cycles and that data is LSB first.
